// File: rtl/linear_layer_start_token_fifo.sv
// Shift-register FIFO carrying start tokens between Linear_Layer_i4xi4_q dataflow processes.
// The read side is first-word-fall-through: if_dout shows the oldest token whenever if_empty_n is high.
module linear_layer_start_token_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [1:0]            dbg_state
);

    // Handshake: a push occurs on a rising edge when if_write & if_write_ce & if_full_n;
    // a pop occurs when if_read & if_read_ce & if_empty_n. Both flags are registered,
    // so neither depends combinationally on the request inputs.

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] srl [DEPTH];
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [ADDR_WIDTH:0]   count_m1;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  push;
    logic                  pop;
    fifo_state_t           state;

    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read & if_read_ce & if_empty_n;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + ONE_C;
            2'b01:   count_next = count - ONE_C;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            if_full_n  <= 1'b1;
            if_empty_n <= 1'b0;
        end else begin
            count      <= count_next;
            if_full_n  <= (count_next != DEPTH_C);
            if_empty_n <= (count_next != '0);
        end
    end

    // Storage carries no reset; a push shifts every entry up by one slot.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                srl[i] <= srl[i-1];
            end
            srl[0] <= if_din;
        end
    end

    // The oldest token sits at count-1; a simultaneous push/pop leaves that index unchanged.
    assign count_m1 = count - ONE_C;
    assign rd_addr  = (count == '0) ? '0 : count_m1[ADDR_WIDTH-1:0];
    assign if_dout  = srl[rd_addr];

    assign if_num_data_valid = count;

    always_comb begin
        state = ST_PARTIAL;
        if (count == '0) begin
            state = ST_EMPTY;
        end else if (count == DEPTH_C) begin
            state = ST_FULL;
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/linear_layer_start_token_fifo.md
# linear_layer_start_token_fifo

Shift-register FIFO that carries start tokens from one dataflow process to the next in the Linear_Layer_i4xi4_q pipeline. A typical use is between the tile scheduler and the PE_i4xi4_pack_2x2 instances. It wraps an SRL-style storage array with full/empty handshake logic and an occupancy counter. The read side is first-word-fall-through, so the consumer's start logic samples `if_dout`/`if_empty_n` with no extra latency.

## Interface
- DATA_WIDTH, 1: token width in bits.
- ADDR_WIDTH, 3: read-address width. Must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- DEPTH, 6: number of storage entries. Must be ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_write_ce  in  1  write-side clock enable. When it is 0, no push happens.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  1 when at least one entry is free.
- if_read_ce  in  1  read-side clock enable. When it is 0, no pop happens.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  oldest stored token (FWFT).
- if_empty_n  out  1  1 when at least one token is stored.
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

## Operation
- push = if_write & if_write_ce & if_full_n. pop = if_read & if_read_ce & if_empty_n. Unqualified requests are ignored and change no state.
- Storage: array SRL[0..DEPTH-1]. On push, every entry shifts up one index (SRL[i+1] ← SRL[i]) and SRL[0] ← if_din. Storage is not reset and is not cleared on pop.
- count register, range 0..DEPTH:
  - push only: count+1.
  - pop only: count−1.
  - both or neither: unchanged.
- Read address rd_addr = count−1 when count > 0, else 0. if_dout = SRL[rd_addr], combinational.
- Simultaneous push and pop: the shift moves the next-oldest entry into SRL[count−1], so rd_addr stays unchanged.
- Derived states (no separate FSM register; decoded from count):
  - EMPTY (count = 0): if_empty_n = 0, if_full_n = 1.
  - PARTIAL (0 < count < DEPTH): both flags 1.
  - FULL (count = DEPTH): if_full_n = 0, if_empty_n = 1.
- Transitions:
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push-only at count = DEPTH−1.
  - FULL→PARTIAL on pop-only.
  - PARTIAL→EMPTY on pop-only at count = 1.
- No bypass: a push into an empty FIFO cannot be popped in the same cycle.
- A push while FULL is blocked, even if pop is asserted, because if_full_n = 0 gates it. A pop while EMPTY is blocked.
- if_full_n and if_empty_n are registers computed from next-count. They are never combinational from the request inputs.
- if_num_data_valid = count.

## Timing
- Reset values:
  - count = 0.
  - if_empty_n = 0.
  - if_full_n = 1.
  - if_num_data_valid = 0.
  - if_dout is undefined (SRL[0] contents) and must only be trusted when if_empty_n = 1.
- Reset asserted mid-operation discards all tokens immediately and asynchronously. Flags return to their reset values without waiting for a clock edge.
- Write-to-read latency: a push at edge N sets if_empty_n = 1 and presents the token on if_dout after edge N.
- Throughput: one push and one pop per cycle, sustained, in the PARTIAL state.
- Full flag: after DEPTH push-only cycles from empty, if_full_n falls after the DEPTH-th edge.
- Empty flag: falls after the edge of the last pop.
- if_dout changes only on a push that lands in the read slot, or on a pop.

## Test plan
All scenarios run with DATA_WIDTH = 8 and DEPTH = 6.
- Reset check: assert reset for 3 cycles, then release. Required: if_empty_n = 0, if_full_n = 1, if_num_data_valid = 0. Holding if_read = 1 while empty changes nothing.
- Fill and drain: push 0x11…0x66 on consecutive cycles. Required: if_full_n = 0 after the 6th edge and if_num_data_valid = 6. A 7th push of 0x77 is dropped. Then pop 6 times. Required: if_dout sequence is 0x11, 0x22, …, 0x66, followed by if_empty_n = 0.
- Streaming: with count = 3, holding 0xA0, 0xA1, 0xA2, push and pop together for 10 cycles, pushing 0xB0…0xB9. Required: count stays at 3 throughout, and output order is 0xA0, 0xA1, 0xA2, 0xB0, ….
- Clock enables: with if_write = 1 and if_write_ce = 0, then if_read = 1 and if_read_ce = 0. Required: count and data unchanged in both cases.
- Full with simultaneous request: at count = 6, assert push 0xCC and pop together. Required: 0x11 is popped, 0xCC is not stored, and count = 5.
- Asynchronous reset mid-operation: at count = 4, pulse reset between clock edges. Required: flags and if_num_data_valid reach their reset values before the next edge, and the next push 0x5A is the first token read out.
